// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg
// Shared definitions for the elastic pipeline register chain:
//   occ_w()   - width of the occupancy count for a given number of slots
//   CNT_W     - width of the statistics counters
//   satAdd()  - saturating add used by the statistics counters
package pipe_chain_pkg;

    localparam int CNT_W = 32;

    function automatic int occ_w(input int stages);
        return $clog2(stages + 1);
    endfunction

    // Clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pipe_chain_slot.sv
// pipe_chain_slot
// One slot of the elastic chain: a valid bit plus a payload register.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   load         - a token transfers into this slot at the next edge
//   flush        - empty this slot at the next edge (wins over everything)
//   unload       - the held token leaves at the next edge
//   loadData     - payload captured on load
//   valid, data  - current slot contents
//   validNext    - next-state valid bit, exposed for the occupancy count
module pipe_chain_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  flush,
    input  logic                  unload,
    input  logic [DATA_WIDTH-1:0] loadData,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  validNext
);

    // Load has priority over unload: a slot that passes its token on and
    // receives a new one in the same cycle stays valid.
    always_comb begin
        validNext = valid;
        if (flush) begin
            validNext = 1'b0;
        end else if (load) begin
            validNext = 1'b1;
        end else if (unload) begin
            validNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else begin
            valid <= validNext;
        end
    end

    // Payload survives a flush; only a transfer into the slot changes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= loadData;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain
// Elastic pipeline register chain of STAGES slots with per-slot flush,
// global stall, downstream back-pressure and registered occupancy.
// Optional statistics counters are built when PIPE_CHAIN_STATS_EN is defined;
// otherwise stall_cycles and flush_count are constant 0.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   in_valid/in_data       - upstream token
//   in_ready               - slot 0 accepts this cycle
//   stall                  - hold every slot
//   flush_mask             - bit i empties slot i at the next edge
//   out_valid/out_data     - token offered by the last slot
//   out_ready              - downstream accepts
//   occupancy              - number of valid slots
//   stall_cycles           - cycles with stall asserted (saturating)
//   flush_count            - valid slots emptied by flush (saturating)
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      in_ready,
    input  logic                      stall,
    input  logic [STAGES-1:0]         flush_mask,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      out_ready,
    output logic [occ_w(STAGES)-1:0]  occupancy,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          flush_count
);

    localparam int OCC_W = occ_w(STAGES);
    localparam int LAST  = STAGES - 1;

    logic [STAGES:0]       acc;
    logic [STAGES-1:0]     leave;
    logic [STAGES-1:0]     load;
    logic [STAGES-1:0]     valid;
    logic [STAGES-1:0]     validNext;
    logic [DATA_WIDTH-1:0] slotData [STAGES];

    function automatic logic [OCC_W-1:0] popCount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Ready ripples from the output back to slot 0. A flushed slot refuses
    // its predecessor, so the predecessor keeps its token.
    always_comb begin
        logic [STAGES:0]   a;
        logic [STAGES-1:0] l;
        a         = '0;
        l         = '0;
        a[STAGES] = out_ready & ~stall;
        for (int i = STAGES - 1; i >= 0; i--) begin
            l[i] = valid[i] & ~flush_mask[i] & a[i+1];
            a[i] = ~stall & ~flush_mask[i] & (~valid[i] | l[i]);
        end
        acc   = a;
        leave = l;
    end

    assign in_ready = acc[0] & ~reset;

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int i = 1; i < STAGES; i++) begin
            load[i] = leave[i-1];
        end
    end

    // Slot registers
    for (genvar g = 0; g < STAGES; g++) begin : gSlot
        pipe_chain_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) uSlot (
            .clk       (clk),
            .reset     (reset),
            .load      (load[g]),
            .flush     (flush_mask[g]),
            .unload    (leave[g]),
            .loadData  ((g == 0) ? in_data : slotData[(g == 0) ? 0 : g - 1]),
            .valid     (valid[g]),
            .data      (slotData[g]),
            .validNext (validNext[g])
        );
    end

    assign out_valid = valid[LAST] & ~flush_mask[LAST] & ~stall;
    assign out_data  = slotData[LAST];

    // Occupancy tracks the valid bits without lag by counting next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= popCount(validNext);
        end
    end

`ifdef PIPE_CHAIN_STATS_EN
    // Only slots that actually held a token count as flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= satAdd(stall_cycles, CNT_W'(1));
            end
            flush_count <= satAdd(flush_count, CNT_W'(popCount(valid & flush_mask)));
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
